// File: rtl/cic_ctrl_pkg.sv
// Shared types and constants for the CIC decimation-rate controller.
// Used by cic_rate_ctrl and cic_dec_counter.
package cic_ctrl_pkg;

   localparam int CFG_W = 8;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_SETTLE = 2'd3
   } state_t;

   // Flush must outlast the M-deep integrator/comb pipeline plus its two register stages.
   function automatic int flush_len(input int m);
      return m + 2;
   endfunction

endpackage

// File: rtl/cic_dec_counter.sv
// Decimation phase counter: counts 0..2^log2r-1 and pulses dec_strobe on the last phase.
// While hold is high the counter is parked at 0 and no strobe is issued.
module cic_dec_counter
   import cic_ctrl_pkg::*;
#(
   parameter int MAX_LOG2R = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold,
   input  logic [CFG_W-1:0] log2r,
   output logic             dec_strobe
);

   localparam logic [MAX_LOG2R-1:0] CNT_ONE = 1;

   logic [MAX_LOG2R-1:0] cnt_reg;
   logic [MAX_LOG2R-1:0] cnt_next;
   logic [MAX_LOG2R-1:0] term_cnt;

   // R-1 as a mask of log2r low ones; log2r == MAX_LOG2R yields all ones.
   assign term_cnt   = ~({MAX_LOG2R{1'b1}} << log2r);
   assign dec_strobe = !hold && (cnt_reg == term_cnt);

   always_comb begin
      cnt_next = cnt_reg + CNT_ONE;
      if (hold || (cnt_reg == term_cnt)) begin
         cnt_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

endmodule

// File: rtl/cic_rate_ctrl.sv
// Run-time decimation-ratio controller for an M-stage CIC decimator: aligns a rate change
// to a strobe boundary, flushes the datapath, then gates output until it has settled.
// Optional CIC_RATE_CTRL_STATUS_EN adds the reconfig_cnt status counter.
module cic_rate_ctrl
   import cic_ctrl_pkg::*;
#(
   parameter int M             = 2,
   parameter int MAX_LOG2R     = 10,
   parameter int DEFAULT_LOG2R = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CFG_W-1:0] cfg_tdata,
   input  logic             cfg_tvalid,
   output logic             cfg_tready,
   output logic             dec_strobe,
   output logic             cic_flush,
   output logic [CFG_W-1:0] shift_amt,
   output logic [CFG_W-1:0] cur_log2r,
   output logic             out_gate,
   output logic             err_range
`ifdef CIC_RATE_CTRL_STATUS_EN
   ,
   output logic [15:0]      reconfig_cnt
`endif
);

   localparam logic [CFG_W-1:0] PHASE_ONE   = 1;
   localparam logic [CFG_W-1:0] FLUSH_LAST  = CFG_W'(flush_len(M) - 1);
   localparam logic [CFG_W-1:0] SETTLE_LAST = CFG_W'(M);
   localparam logic [CFG_W-1:0] LOG2R_MAX   = CFG_W'(MAX_LOG2R);
   localparam logic [CFG_W-1:0] LOG2R_RST   = CFG_W'(DEFAULT_LOG2R);
   localparam logic [CFG_W-1:0] SHIFT_RST   = CFG_W'(M * DEFAULT_LOG2R);

   state_t           state_reg;
   state_t           state_next;
   logic [CFG_W-1:0] cur_log2r_reg;
   logic [CFG_W-1:0] pend_log2r_reg;
   logic [CFG_W-1:0] shift_amt_reg;
   logic [CFG_W-1:0] phase_cnt_reg;
   logic             err_range_reg;
   logic             req_fire;
   logic             req_bad;

   assign req_fire = (state_reg == ST_RUN) && cfg_tvalid;
   assign req_bad  = (cfg_tdata == '0) || (cfg_tdata > LOG2R_MAX);

   cic_dec_counter #(
      .MAX_LOG2R (MAX_LOG2R)
   ) u_dec_counter (
      .clk        (clk),
      .rst        (rst),
      .hold       (state_reg == ST_FLUSH),
      .log2r      (cur_log2r_reg),
      .dec_strobe (dec_strobe)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RUN: begin
            if (req_fire && !req_bad && (cfg_tdata != cur_log2r_reg)) begin
               state_next = ST_ALIGN;
            end
         end
         ST_ALIGN: begin
            if (dec_strobe) begin
               state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (phase_cnt_reg == FLUSH_LAST) begin
               state_next = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (dec_strobe && (phase_cnt_reg == SETTLE_LAST)) begin
               state_next = ST_RUN;
            end
         end
         default: state_next = ST_SETTLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_SETTLE;
         cur_log2r_reg  <= LOG2R_RST;
         pend_log2r_reg <= '0;
         shift_amt_reg  <= SHIFT_RST;
         phase_cnt_reg  <= '0;
         err_range_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (req_fire && req_bad) begin
            err_range_reg <= 1'b1;
         end
         if ((state_reg == ST_RUN) && (state_next == ST_ALIGN)) begin
            pend_log2r_reg <= cfg_tdata;
         end
         // New ratio and its gain compensation take effect together with the flush.
         if ((state_reg == ST_ALIGN) && (state_next == ST_FLUSH)) begin
            cur_log2r_reg <= pend_log2r_reg;
            shift_amt_reg <= CFG_W'(M * int'(pend_log2r_reg));
         end
         // Phase counter is shared: flush cycles in FLUSH, strobes seen in SETTLE.
         if (state_next != state_reg) begin
            phase_cnt_reg <= '0;
         end else if ((state_reg == ST_FLUSH) || ((state_reg == ST_SETTLE) && dec_strobe)) begin
            phase_cnt_reg <= phase_cnt_reg + PHASE_ONE;
         end
      end
   end

   assign cfg_tready = (state_reg == ST_RUN);
   assign cic_flush  = (state_reg == ST_FLUSH);
   assign out_gate   = (state_reg == ST_RUN) || (state_reg == ST_ALIGN);
   assign cur_log2r  = cur_log2r_reg;
   assign shift_amt  = shift_amt_reg;
   assign err_range  = err_range_reg;

`ifdef CIC_RATE_CTRL_STATUS_EN
   logic        flushed_reg;
   logic [15:0] reconfig_cnt_reg;

   // Only a settle that follows a flush is a reconfiguration; the post-reset settle is not.
   always_ff @(posedge clk) begin
      if (rst) begin
         flushed_reg      <= 1'b0;
         reconfig_cnt_reg <= '0;
      end else if (state_reg == ST_FLUSH) begin
         flushed_reg <= 1'b1;
      end else if ((state_reg == ST_SETTLE) && (state_next == ST_RUN)) begin
         flushed_reg <= 1'b0;
         if (flushed_reg && (reconfig_cnt_reg != 16'hFFFF)) begin
            reconfig_cnt_reg <= reconfig_cnt_reg + 16'd1;
         end
      end
   end

   assign reconfig_cnt = reconfig_cnt_reg;
`endif

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed bench for cic_rate_ctrl; define CIC_RATE_CTRL_STATUS_EN to also check reconfig_cnt.
module tb_cic_rate_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] cfg_tdata;
   logic       cfg_tvalid;
   logic       cfg_tready;
   logic       dec_strobe;
   logic       cic_flush;
   logic [7:0] shift_amt;
   logic [7:0] cur_log2r;
   logic       out_gate;
   logic       err_range;
`ifdef CIC_RATE_CTRL_STATUS_EN
   logic [15:0] reconfig_cnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cic_rate_ctrl #(.M(2), .MAX_LOG2R(10), .DEFAULT_LOG2R(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_tdata  (cfg_tdata),
      .cfg_tvalid (cfg_tvalid),
      .cfg_tready (cfg_tready),
      .dec_strobe (dec_strobe),
      .cic_flush  (cic_flush),
      .shift_amt  (shift_amt),
      .cur_log2r  (cur_log2r),
      .out_gate   (out_gate),
      .err_range  (err_range)
`ifdef CIC_RATE_CTRL_STATUS_EN
      ,
      .reconfig_cnt (reconfig_cnt)
`endif
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; cfg_tvalid = 1'b0; cfg_tdata = 8'd0;
      repeat (3) tick();
      checks++;
      if ({dec_strobe, cfg_tready, cic_flush, out_gate, err_range} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 00000", {dec_strobe, cfg_tready, cic_flush, out_gate, err_range});
      end
      checks++;
      if (cur_log2r !== 8'd5) begin errors++; $display("FAIL reset_cur: got %0d want 5", cur_log2r); end
      checks++;
      if (shift_amt !== 8'd10) begin errors++; $display("FAIL reset_shift: got %0d want 10", shift_amt); end
`ifdef CIC_RATE_CTRL_STATUS_EN
      checks++;
      if (reconfig_cnt !== 16'd0) begin errors++; $display("FAIL reset_rcnt: got %0d want 0", reconfig_cnt); end
`endif
   endtask

   // Release reset on the current negedge (cycle 0) and run to the first RUN cycle (96).
   task automatic test_startup();
      rst = 1'b0;
      for (int k = 0; k <= 96; k++) begin
         if (k != 0) tick();
         checks++;
         if (dec_strobe !== ((k % 32) == 31)) begin
            errors++; $display("FAIL start_strobe k=%0d: got %0d want %0d", k, dec_strobe, ((k % 32) == 31));
         end
         checks++;
         if (out_gate !== (k >= 96)) begin
            errors++; $display("FAIL start_gate k=%0d: got %0d want %0d", k, out_gate, (k >= 96));
         end
         checks++;
         if (cfg_tready !== (k >= 96)) begin
            errors++; $display("FAIL start_tready k=%0d: got %0d want %0d", k, cfg_tready, (k >= 96));
         end
      end
      checks++;
      if (shift_amt !== 8'd10) begin errors++; $display("FAIL start_shift: got %0d want 10", shift_amt); end
`ifdef CIC_RATE_CTRL_STATUS_EN
      checks++;
      if (reconfig_cnt !== 16'd0) begin errors++; $display("FAIL start_rcnt: got %0d want 0", reconfig_cnt); end
`endif
   endtask

   // Starts at cnt=0 in RUN with log2r=5; ends at cnt=10.
   task automatic test_range_err();
      cfg_tvalid = 1'b1; cfg_tdata = 8'd0;
      $display("req tdata=0 (out of range)");
      tick();
      checks++;
      if (err_range !== 1'b1) begin errors++; $display("FAIL err_zero: got %0d want 1", err_range); end
      cfg_tdata = 8'd11;
      $display("req tdata=11 (out of range)");
      tick();
      checks++;
      if ({err_range, cfg_tready, out_gate} !== 3'b111) begin
         errors++; $display("FAIL err_state: got %b want 111", {err_range, cfg_tready, out_gate});
      end
      checks++;
      if (cur_log2r !== 8'd5) begin errors++; $display("FAIL err_cur: got %0d want 5", cur_log2r); end
      cfg_tdata = 8'd5;
      $display("req tdata=5 (same as current)");
      tick();
      checks++;
      if ({cfg_tready, out_gate, cic_flush} !== 3'b110) begin
         errors++; $display("FAIL same_noop: got %b want 110", {cfg_tready, out_gate, cic_flush});
      end
      cfg_tvalid = 1'b0;
      repeat (7) tick();
   endtask

   // Starts at cnt=10 in RUN with log2r=5; ends on the first RUN cycle at log2r=3.
   task automatic test_reconfig();
      checks++;
      if (cfg_tready !== 1'b1) begin errors++; $display("FAIL rc_tready: got %0d want 1", cfg_tready); end
      cfg_tvalid = 1'b1; cfg_tdata = 8'd3;
      $display("req tdata=3 at cnt=10");
      tick();
      cfg_tvalid = 1'b0;
      checks++;
      if ({cfg_tready, out_gate, cic_flush} !== 3'b010) begin
         errors++; $display("FAIL rc_align: got %b want 010", {cfg_tready, out_gate, cic_flush});
      end
      checks++;
      if (cur_log2r !== 8'd5) begin errors++; $display("FAIL rc_align_cur: got %0d want 5", cur_log2r); end
      for (int c = 11; c <= 31; c++) begin
         if (c != 11) tick();
         checks++;
         if ({dec_strobe, cic_flush} !== {(c == 31), 1'b0}) begin
            errors++; $display("FAIL rc_align_strobe cnt=%0d: got %b want %b", c, {dec_strobe, cic_flush}, {(c == 31), 1'b0});
         end
      end
      for (int f = 0; f < 4; f++) begin
         tick();
         checks++;
         if ({cic_flush, out_gate, dec_strobe, cfg_tready} !== 4'b1000) begin
            errors++; $display("FAIL rc_flush f=%0d: got %b want 1000", f, {cic_flush, out_gate, dec_strobe, cfg_tready});
         end
         checks++;
         if ({cur_log2r, shift_amt} !== {8'd3, 8'd6}) begin
            errors++; $display("FAIL rc_flush_cfg f=%0d: got cur=%0d shift=%0d want cur=3 shift=6", f, cur_log2r, shift_amt);
         end
      end
      for (int s = 0; s <= 24; s++) begin
         tick();
         checks++;
         if ({dec_strobe, out_gate, cic_flush} !== {((s % 8) == 7), (s == 24), 1'b0}) begin
            errors++;
            $display("FAIL rc_settle s=%0d: got %b want %b", s, {dec_strobe, out_gate, cic_flush}, {((s % 8) == 7), (s == 24), 1'b0});
         end
      end
      checks++;
      if (cfg_tready !== 1'b1) begin errors++; $display("FAIL rc_run_tready: got %0d want 1", cfg_tready); end
`ifdef CIC_RATE_CTRL_STATUS_EN
      checks++;
      if (reconfig_cnt !== 16'd1) begin errors++; $display("FAIL rc_rcnt: got %0d want 1", reconfig_cnt); end
`endif
   endtask

   // Starts at cnt=0 in RUN with log2r=3; ends mid-FLUSH (i=76) of the change back to 5.
   task automatic test_tvalid_hold();
      int bad = 0;
      cfg_tvalid = 1'b1; cfg_tdata = 8'd4;
      $display("req tdata=4 accepted, then tdata=5 held valid");
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (i == 1) cfg_tdata = 8'd5;
         if (cfg_tready !== (i == 60)) bad++;
         if (i == 8) begin
            checks++;
            if ({cic_flush, cur_log2r, shift_amt} !== {1'b1, 8'd4, 8'd8}) begin
               errors++; $display("FAIL hold_flush: got flush=%0d cur=%0d shift=%0d want 1 4 8", cic_flush, cur_log2r, shift_amt);
            end
         end
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL hold_tready: got %0d wrong cycles want 0", bad); end
      checks++;
      if ({cfg_tready, out_gate} !== 2'b11) begin errors++; $display("FAIL hold_run: got %b want 11", {cfg_tready, out_gate}); end
`ifdef CIC_RATE_CTRL_STATUS_EN
      checks++;
      if (reconfig_cnt !== 16'd2) begin errors++; $display("FAIL hold_rcnt: got %0d want 2", reconfig_cnt); end
`endif
      tick();
      cfg_tvalid = 1'b0;
      checks++;
      if ({cfg_tready, out_gate} !== 2'b01) begin errors++; $display("FAIL hold_accept: got %b want 01", {cfg_tready, out_gate}); end
      for (int i = 62; i <= 76; i++) begin
         tick();
         if (i == 75) begin
            checks++;
            if (dec_strobe !== 1'b1) begin errors++; $display("FAIL hold_align_strobe: got %0d want 1", dec_strobe); end
         end
      end
      checks++;
      if ({cic_flush, cur_log2r, shift_amt} !== {1'b1, 8'd5, 8'd10}) begin
         errors++; $display("FAIL hold_flush2: got flush=%0d cur=%0d shift=%0d want 1 5 10", cic_flush, cur_log2r, shift_amt);
      end
   endtask

   // Reset pulse mid-FLUSH, then reset pulse mid-ALIGN (pending must be discarded).
   task automatic test_rst_override();
      int flush_seen = 0;
      tick();
      rst = 1'b1;
      $display("rst pulse during FLUSH");
      tick();
      rst = 1'b0;
      checks++;
      if ({cic_flush, cfg_tready, out_gate, err_range} !== 4'b0000) begin
         errors++; $display("FAIL rstf_flags: got %b want 0000", {cic_flush, cfg_tready, out_gate, err_range});
      end
      checks++;
      if ({cur_log2r, shift_amt} !== {8'd5, 8'd10}) begin
         errors++; $display("FAIL rstf_cfg: got cur=%0d shift=%0d want 5 10", cur_log2r, shift_amt);
      end
`ifdef CIC_RATE_CTRL_STATUS_EN
      checks++;
      if (reconfig_cnt !== 16'd0) begin errors++; $display("FAIL rstf_rcnt: got %0d want 0", reconfig_cnt); end
`endif
      repeat (96) tick();
      checks++;
      if ({cfg_tready, out_gate} !== 2'b11) begin errors++; $display("FAIL rstf_run: got %b want 11", {cfg_tready, out_gate}); end
      cfg_tvalid = 1'b1; cfg_tdata = 8'd11;
      $display("req tdata=11 (out of range)");
      tick();
      checks++;
      if ({err_range, cfg_tready, cur_log2r} !== {1'b1, 1'b1, 8'd5}) begin
         errors++; $display("FAIL err_high: got err=%0d tready=%0d cur=%0d want 1 1 5", err_range, cfg_tready, cur_log2r);
      end
      cfg_tdata = 8'd4;
      $display("req tdata=4, then rst during ALIGN");
      tick();
      cfg_tvalid = 1'b0;
      checks++;
      if ({cfg_tready, out_gate} !== 2'b01) begin errors++; $display("FAIL rsta_align: got %b want 01", {cfg_tready, out_gate}); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({cfg_tready, out_gate, err_range, cur_log2r} !== {1'b0, 1'b0, 1'b0, 8'd5}) begin
         errors++; $display("FAIL rsta_flags: got tready=%0d gate=%0d err=%0d cur=%0d want 0 0 0 5", cfg_tready, out_gate, err_range, cur_log2r);
      end
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (cic_flush) flush_seen++;
      end
      checks++;
      if (flush_seen != 0) begin errors++; $display("FAIL rsta_discard: got %0d flush cycles want 0", flush_seen); end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_range_err();
      test_reconfig();
      test_tvalid_hold();
      test_rst_override();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cic_rate_ctrl.md
CIC_RATE_CTRL -- requirements
Module: cic_rate_ctrl

Interface
REQ-001 SHALL have parameter M, default 2, number of CIC stages in the controlled decimator.
REQ-002 SHALL have parameter MAX_LOG2R, default 10, largest accepted log2 of decimation ratio R.
REQ-003 SHALL have parameter DEFAULT_LOG2R, default 5, log2 R applied after reset.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cfg_tdata  input  8  requested log2 R.
REQ-007 SHALL have port cfg_tvalid  input  1  request valid.
REQ-008 SHALL have port cfg_tready  output  1  request accepted when high with cfg_tvalid.
REQ-009 SHALL have port dec_strobe  output  1  one-cycle decimation pulse to the datapath.
REQ-010 SHALL have port cic_flush  output  1  synchronous clear to the datapath.
REQ-011 SHALL have port shift_amt  output  8  output scaling shift, M*cur_log2r.
REQ-012 SHALL have port cur_log2r  output  8  active log2 R.
REQ-013 SHALL have port out_gate  output  1  datapath output trustworthy.
REQ-014 SHALL have port err_range  output  1  sticky out-of-range request flag.

Function
REQ-015 SHALL implement states RUN, ALIGN, FLUSH, SETTLE.
REQ-016 SHALL keep a MAX_LOG2R-bit counter cnt: +1 per cycle in RUN/ALIGN/SETTLE; wraps to 0 after R-1, R=2^cur_log2r; held 0 in FLUSH.
REQ-017 SHALL drive dec_strobe high exactly on cycles with cnt==R-1 outside FLUSH, else low.
REQ-018 SHALL drive cfg_tready high only in RUN.
REQ-019 On accepted request with value 0 or >MAX_LOG2R: set err_range, stay RUN, no other change.
REQ-020 On accepted request equal to cur_log2r: no-op, stay RUN.
REQ-021 On accepted valid, different request: latch pending, enter ALIGN next cycle; out_gate unchanged.
REQ-022 ALIGN SHALL exit to FLUSH on the cycle after the next dec_strobe.
REQ-023 On FLUSH entry, cur_log2r SHALL take pending and shift_amt SHALL become M*pending in the same cycle.
REQ-024 FLUSH SHALL assert cic_flush for exactly M+2 cycles, out_gate low, then enter SETTLE.
REQ-025 SETTLE SHALL keep out_gate low until M+1 dec_strobes occur, then enter RUN with out_gate high the following cycle.
REQ-026 err_range SHALL clear only on rst.

Reset
REQ-027 rst SHALL give state SETTLE, cnt 0, cur_log2r DEFAULT_LOG2R, shift_amt M*DEFAULT_LOG2R, out_gate 0, cic_flush 0, dec_strobe 0, cfg_tready 0, err_range 0, pending discarded.
REQ-028 rst SHALL override every state, including mid-FLUSH and mid-ALIGN.

Configuration
REQ-029 With CIC_RATE_CTRL_STATUS_EN defined: SHALL add output reconfig_cnt (16 bits) that counts SETTLE-to-RUN transitions following a FLUSH, saturates at 65535, and resets to 0.
REQ-030 Without CIC_RATE_CTRL_STATUS_EN: port and counter SHALL be absent; other behaviour identical.

Structure
REQ-031 Package cic_ctrl_pkg SHALL hold the state enum, the FLUSH_LEN (M+2) function, and the cfg width constant of 8.
REQ-032 Submodule cic_dec_counter SHALL implement cnt/dec_strobe with hold and log2r inputs.

Verification
REQ-033 Release reset (defaults): dec_strobe at cycles 31, 63, 95 after release; out_gate rises at cycle 96; shift_amt=10.
REQ-034 cfg_tdata=3 at cnt=10: tready=1 that cycle, ALIGN until strobe at cnt=31, cic_flush 4 cycles, shift_amt=6, strobes every 8 cycles, out_gate high one cycle after the 3rd strobe.
REQ-035 cfg_tdata=0 then 11: err_range=1, state RUN, cur_log2r stays 5, out_gate stays 1.
REQ-036 tvalid held during FLUSH/SETTLE: tready=0 until RUN, accepted on the first RUN cycle.
REQ-037 rst pulsed during FLUSH: next cycle cic_flush=0, cur_log2r=5, state SETTLE.
REQ-038 CIC_RATE_CTRL_STATUS_EN defined, two valid reconfigs: reconfig_cnt=2; a rejected request does not increment it.
